if_fetch_unit: RTL and testbench

- Instruction-fetch initiator for the instruction memory (IM). Owns the architectural PC and drives the IM read address.
- Takes the returned instruction word, checks the fetch address, and registers the result into the IF/ID pipeline register.
- Handles stalls, branch/jump redirects, exception entry and ERET return.
- Sits between the hazard/CP0 logic and the decode stage.

---
 rtl/if_fetch_unit.sv | 139 +++++++++++++
 tb/tb_if_fetch_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch: PC ownership, fetch address check, IF/ID register (perf counters under IF_FETCH_PERF_EN)
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] IM_BASE    = 32'h0000_3000,
    parameter logic [31:0] IM_TOP     = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    input  logic        id_is_branch,
    output logic [31:0] im_pc,
    input  logic [31:0] im_instr,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc8,
    output logic        if_id_valid,
    output logic        if_id_bd,
    output logic [4:0]  if_id_exccode
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ifpc_q, ifpc_d;
    logic [31:0] pc8_q, pc8_d;
    logic        valid_q, valid_d;
    logic        bd_q, bd_d;
    logic [4:0]  exc_q, exc_d;
    logic        fetch_err;
    logic        flush;
    logic        capture;

    assign im_pc = pc_q;

    // A bad fetch address is not fatal here: it travels down as a nop tagged AdEL.
    assign fetch_err = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) || (pc_q > IM_TOP);
    assign flush     = exc_req || eret_req;
    assign capture   = !flush && !stall;

    // Next PC and next IF/ID contents; exception beats ERET beats stall beats redirect.
    always_comb begin
        pc_d    = pc_q + 32'd4;
        instr_d = instr_q;
        ifpc_d  = ifpc_q;
        pc8_d   = pc8_q;
        valid_d = valid_q;
        bd_d    = bd_q;
        exc_d   = exc_q;
        if (flush) begin
            pc_d    = exc_req ? HANDLER_PC : epc;
            instr_d = 32'h0;
            ifpc_d  = pc_d;
            pc8_d   = pc_d + 32'd8;
            valid_d = 1'b0;
            bd_d    = 1'b0;
            exc_d   = EXC_NONE;
        end else if (stall) begin
            pc_d = pc_q;
        end else begin
            if (br_taken) begin
                pc_d = br_target;
            end
            instr_d = fetch_err ? 32'h0 : im_instr;
            ifpc_d  = pc_q;
            pc8_d   = pc_q + 32'd8;
            valid_d = 1'b1;
            bd_d    = id_is_branch;
            exc_d   = fetch_err ? EXC_ADEL : EXC_NONE;
        end
    end

    // PC and IF/ID state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            ifpc_q  <= 32'h0;
            pc8_q   <= 32'h0;
            valid_q <= 1'b0;
            bd_q    <= 1'b0;
            exc_q   <= EXC_NONE;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ifpc_q  <= ifpc_d;
            pc8_q   <= pc8_d;
            valid_q <= valid_d;
            bd_q    <= bd_d;
            exc_q   <= exc_d;
        end
    end

    assign if_id_instr   = instr_q;
    assign if_id_pc      = ifpc_q;
    assign if_id_pc8     = pc8_q;
    assign if_id_valid   = valid_q;
    assign if_id_bd      = bd_q;
    assign if_id_exccode = exc_q;

`ifdef IF_FETCH_PERF_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    // Free-running wrap-around counters of capture cycles and non-flush stall cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q <= 32'h0;
            stall_cnt_q <= 32'h0;
        end else begin
            if (capture) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (stall && !flush) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`else
    logic unused_capture;
    assign unused_capture = capture;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - scoreboard testbench for if_fetch_unit
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
    localparam logic [31:0] IM_BASE    = 32'h0000_3000;
    localparam logic [31:0] IM_TOP     = 32'h0000_6FFC;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc8;
        logic        valid;
        logic        bd;
        logic [4:0]  exc;
    } ifid_t;

    logic        clk = 1'b0;
    logic        reset, stall, br_taken, exc_req, eret_req, id_is_branch;
    logic [31:0] br_target, epc, im_pc, im_instr;
    logic [31:0] if_id_instr, if_id_pc, if_id_pc8;
    logic        if_id_valid, if_id_bd;
    logic [4:0]  if_id_exccode;
`ifdef IF_FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    ifid_t       exp_q[$];
    ifid_t       m_ifid;
    logic [31:0] m_pc;
    int          m_fetches;
    int          m_stalls;

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken),
        .br_target(br_target), .exc_req(exc_req), .eret_req(eret_req), .epc(epc),
        .id_is_branch(id_is_branch), .im_pc(im_pc), .im_instr(im_instr),
        .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_pc8(if_id_pc8),
        .if_id_valid(if_id_valid), .if_id_bd(if_id_bd), .if_id_exccode(if_id_exccode)
`ifdef IF_FETCH_PERF_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    function automatic logic [31:0] im_word(input logic [31:0] a);
        case (a)
            32'h0000_3000: return 32'h1111_1111;
            32'h0000_3004: return 32'h2222_2222;
            32'h0000_3008: return 32'h3333_3333;
            default:       return {a[15:0], ~a[15:0]};
        endcase
    endfunction

    assign im_instr = im_word(im_pc);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, predict, clock, compare the popped expectation.
    task automatic step(input logic rst, input logic stl, input logic br, input logic [31:0] tgt,
                        input logic exc, input logic ert, input logic [31:0] ep, input logic isbr);
        ifid_t e;
        ifid_t got;
        logic  err;
        logic [31:0] npc;
        @(negedge clk);
        reset = rst; stall = stl; br_taken = br; br_target = tgt;
        exc_req = exc; eret_req = ert; epc = ep; id_is_branch = isbr;
        #1;
        if (!rst) check("im_pc", im_pc, m_pc);
        err = (m_pc[1:0] != 2'b00) || (m_pc < IM_BASE) || (m_pc > IM_TOP);
        if (rst) begin
            npc = RESET_PC;
            e = '{32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0};
            m_fetches = 0; m_stalls = 0;
        end else if (exc || ert) begin
            npc = exc ? HANDLER_PC : ep;
            e = '{32'h0, npc, npc + 32'd8, 1'b0, 1'b0, 5'd0};
        end else if (stl) begin
            npc = m_pc;
            e = m_ifid;
            m_stalls++;
        end else begin
            npc = br ? tgt : m_pc + 32'd4;
            e = '{err ? 32'h0 : im_word(m_pc), m_pc, m_pc + 32'd8, 1'b1, isbr, err ? 5'd4 : 5'd0};
            m_fetches++;
        end
        exp_q.push_back(e);
        m_pc = npc;
        m_ifid = e;
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        check("if_id_instr", if_id_instr, got.instr);
        check("if_id_pc", if_id_pc, got.pc);
        check("if_id_pc8", if_id_pc8, got.pc8);
        check("if_id_valid", {31'h0, if_id_valid}, {31'h0, got.valid});
        check("if_id_bd", {31'h0, if_id_bd}, {31'h0, got.bd});
        check("if_id_exccode", {27'h0, if_id_exccode}, {27'h0, got.exc});
    endtask

    task automatic free(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0, 0, 0, 32'h0, 0);
    endtask

    task automatic branch_to(input logic [31:0] t);
        step(0, 0, 1, t, 0, 0, 32'h0, 0);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = 32'h0;
        exc_req = 1'b0; eret_req = 1'b0; epc = 32'h0; id_is_branch = 1'b0;
        m_pc = RESET_PC;
        m_ifid = '{32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0};
        m_fetches = 0; m_stalls = 0;

        step(1, 0, 0, 32'h0, 0, 0, 32'h0, 0);
        step(1, 0, 0, 32'h0, 0, 0, 32'h0, 0);
        check("reset_im_pc", im_pc, 32'h0000_3000);

        // Sequential fetch of the three seeded words.
        free(1);
        check("first_instr", if_id_instr, 32'h1111_1111);
        check("first_pc8", if_id_pc8, 32'h0000_3008);
        free(2);
        check("third_instr", if_id_instr, 32'h3333_3333);

        // Two-cycle stall, then resume.
        step(0, 1, 0, 32'h0, 0, 0, 32'h0, 0);
        step(0, 1, 0, 32'h0, 0, 0, 32'h0, 0);
        check("stall_hold_pc", im_pc, 32'h0000_300C);
        free(1);

        // Branch with delay slot; a stalled redirect is dropped.
        step(0, 1, 1, 32'h0000_5000, 0, 0, 32'h0, 1);
        step(0, 0, 1, 32'h0000_3100, 0, 0, 32'h0, 1);
        check("delay_slot_bd", {31'h0, if_id_bd}, 32'h1);
        check("redirect_pc", im_pc, 32'h0000_3100);
        free(2);

        // Exception beats stall/branch/eret; then ERET.
        step(0, 1, 1, 32'h0000_3200, 1, 1, 32'h0000_3300, 1);
        check("exc_pc", im_pc, 32'h0000_4180);
        check("exc_ifid_pc", if_id_pc, 32'h0000_4180);
        free(1);
        step(0, 1, 0, 32'h0, 0, 1, 32'h0000_3010, 0);
        check("eret_pc", im_pc, 32'h0000_3010);
        free(2);

        // Address errors: misaligned, below base, above top; boundary at top is legal.
        branch_to(32'h0000_3002); free(1);
        check("misalign_exc", {27'h0, if_id_exccode}, 32'd4);
        branch_to(32'h0000_2FFC); free(1);
        branch_to(32'h0000_7000); free(1);
        branch_to(32'h0000_6FFC); free(2);
        // PC wraps past 2^32 without trapping.
        branch_to(32'hFFFF_FFFC); free(2);
        check("wrap_pc", if_id_pc, 32'h0000_0000);

        // Reset wins over a concurrent stall and flush.
        step(1, 1, 0, 32'h0, 1, 0, 32'h0, 0);
        check("reset_mid_pc", im_pc, 32'h0000_3000);

        // Perf counters: 5 fetches, 2 stalls, 1 exception.
        free(3);
        step(0, 1, 0, 32'h0, 0, 0, 32'h0, 0);
        step(0, 1, 0, 32'h0, 0, 0, 32'h0, 0);
        free(2);
        step(0, 0, 0, 32'h0, 1, 0, 32'h0, 0);
`ifdef IF_FETCH_PERF_EN
        check("perf_fetch", perf_fetch_cnt, 32'd5);
        check("perf_stall", perf_stall_cnt, 32'd2);
        check("perf_fetch_model", perf_fetch_cnt, m_fetches);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
